// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
//   Multi-cycle multiply/divide unit for the EXE stage. One MULT/MULTU/DIV/DIVU
//   operation is in flight at a time. An operation is requested with start and
//   tracked with busy. Results appear on hi/lo with a one-cycle done pulse and
//   stay registered until the next result is committed.
//
//   Multiply: the product is formed from latched operands and held for MUL_LAT
//   cycles before it is committed.
//   Divide:   restoring, one quotient bit per cycle on magnitudes, then a sign
//             fix-up cycle. Divide by zero short-circuits after one cycle.
//
// Parameters
//   WIDTH    operand width; hi and lo are WIDTH bits each
//   MUL_LAT  cycles spent in MUL before DONE (1..15)
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   start        in   operation request, accepted when busy=0 and cancel=0
//   op           in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   src1         in   multiplicand / dividend
//   src2         in   multiplier / divisor
//   cancel       in   abort the in-flight operation (exception/flush)
//   busy         out  high while an operation is in progress
//   done         out  one-cycle pulse; hi/lo/div_by_zero valid
//   hi           out  product upper half / remainder
//   lo           out  product lower half / quotient
//   div_by_zero  out  with done: the divide had a zero divisor
// -----------------------------------------------------------------------------
module md_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    // Counter must reach both the divide iteration count and the multiply hold.
    localparam int CNT_W = $clog2(((WIDTH > MUL_LAT) ? WIDTH : MUL_LAT) + 1);

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [WIDTH-1:0] f_cond_neg(
        input logic [WIDTH-1:0] v,
        input logic             neg
    );
        logic [WIDTH-1:0] res;
        if (neg) begin
            res = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = v;
        end
        return res;
    endfunction

    state_t r_state;
    state_t w_next;

    // Latched operation context
    logic             r_signed;   // op[0]==0: MULT or DIV
    logic [WIDTH-1:0] r_a;        // raw src1
    logic [WIDTH-1:0] r_b;        // raw src2
    logic [CNT_W-1:0] r_cnt;

    // Divider datapath: r_quo starts as |dividend| and fills with quotient bits
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic             r_neg_q;
    logic             r_neg_r;

    // Result registers
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dbz;

    // Control strobes decoded from the state
    logic w_busy;
    logic w_done;
    logic w_accept;
    logic w_load_mul;
    logic w_load_dbz;
    logic w_load_div;
    logic w_div_step;

    // Accept-time operand conditioning
    logic             w_in_signed;
    logic             w_s1_neg;
    logic             w_s2_neg;
    logic             w_dvs_zero;

    // Multiply / divide datapath wires
    logic [2*WIDTH-1:0] w_mul_a;
    logic [2*WIDTH-1:0] w_mul_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;

    assign w_in_signed = ~op[0];
    assign w_s1_neg    = w_in_signed & src1[WIDTH-1];
    assign w_s2_neg    = w_in_signed & src2[WIDTH-1];
    assign w_dvs_zero  = (r_dvs == {WIDTH{1'b0}});

    // Extending to 2*WIDTH and keeping the low 2*WIDTH bits of the product
    // gives the same result as a (WIDTH+1)-bit signed/unsigned multiply.
    assign w_mul_a = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
    assign w_mul_b = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
    assign w_prod  = w_mul_a * w_mul_b;

    // Restoring step. Since r_rem < r_dvs, w_shift < 2*r_dvs, so the top bit of
    // the difference is a clean borrow indicator.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_ge    = ~w_diff[WIDTH];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = op[1] ? S_DIV : S_MUL;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_MUL: begin
                if (cancel) begin
                    w_next = S_IDLE;
                end else if (w_load_mul) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_MUL;
                end
            end
            S_DIV: begin
                if (cancel) begin
                    w_next = S_IDLE;
                end else if (w_dvs_zero) begin
                    w_next = S_DONE;
                end else if (r_cnt == DIV_LAST) begin
                    w_next = S_FIX;
                end else begin
                    w_next = S_DIV;
                end
            end
            S_FIX: begin
                if (cancel) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_next = op[1] ? S_DIV : S_MUL;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Output / strobe decode from the current state
    always_comb begin
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_accept   = 1'b0;
        w_load_mul = 1'b0;
        w_load_dbz = 1'b0;
        w_load_div = 1'b0;
        w_div_step = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = start & ~cancel;
            end
            S_MUL: begin
                w_busy     = 1'b1;
                w_load_mul = ~cancel & (r_cnt == MUL_LAST);
            end
            S_DIV: begin
                w_busy     = 1'b1;
                w_load_dbz = ~cancel & w_dvs_zero;
                w_div_step = ~cancel & ~w_dvs_zero;
            end
            S_FIX: begin
                w_busy     = 1'b1;
                w_load_div = ~cancel;
            end
            S_DONE: begin
                w_done   = 1'b1;
                w_accept = start & ~cancel;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Operand latch, iteration counter and divider shift registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_signed <= 1'b0;
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_dvs    <= {WIDTH{1'b0}};
            r_rem    <= {WIDTH{1'b0}};
            r_quo    <= {WIDTH{1'b0}};
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (w_accept) begin
            r_signed <= w_in_signed;
            r_a      <= src1;
            r_b      <= src2;
            r_cnt    <= {CNT_W{1'b0}};
            r_dvs    <= f_cond_neg(src2, w_s2_neg);
            r_rem    <= {WIDTH{1'b0}};
            r_quo    <= f_cond_neg(src1, w_s1_neg);
            r_neg_q  <= w_s1_neg ^ w_s2_neg;
            r_neg_r  <= w_s1_neg;
        end else begin
            if (w_busy) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
            if (w_div_step) begin
                r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], w_ge};
            end else begin
                r_rem <= r_rem;
                r_quo <= r_quo;
            end
        end
    end

    // Result registers, written only on the edge that enters DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi  <= {WIDTH{1'b0}};
            r_lo  <= {WIDTH{1'b0}};
            r_dbz <= 1'b0;
        end else if (w_load_mul) begin
            r_hi  <= w_prod[2*WIDTH-1:WIDTH];
            r_lo  <= w_prod[WIDTH-1:0];
            r_dbz <= 1'b0;
        end else if (w_load_dbz) begin
            r_hi  <= r_a;
            r_lo  <= {WIDTH{1'b1}};
            r_dbz <= 1'b1;
        end else if (w_load_div) begin
            r_hi  <= f_cond_neg(r_rem, r_neg_r);
            r_lo  <= f_cond_neg(r_quo, r_neg_q);
            r_dbz <= 1'b0;
        end else begin
            r_hi  <= r_hi;
            r_lo  <= r_lo;
            r_dbz <= r_dbz;
        end
    end

    assign busy        = w_busy;
    assign done        = w_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule
